// File: rtl/dig_display_pkg.sv
// Shared peripheral address map and output-bundle types for the 7-segment display block.
// The display parameters default to the addresses defined here.
package dig_display_pkg;

    localparam logic [31:0] DIG_DATA_ADDR = 32'hFFFF_F000;
    localparam logic [31:0] DIG_MASK_ADDR = 32'hFFFF_F004;
    localparam logic [31:0] DIG_DP_ADDR   = 32'hFFFF_F008;

    typedef struct packed {
        logic [7:0] dig_en;
        logic [6:0] seg_n;   // {g,f,e,d,c,b,a}, active-low
        logic       dp_n;
    } disp_out_t;

    localparam disp_out_t DISP_BLANK = '{dig_en: 8'hFF, seg_n: 7'h7F, dp_n: 1'b1};

endpackage

// File: rtl/dig_display_seg7.sv
// Combinational hex-to-7-segment decoder; output bits are {g,f,e,d,c,b,a}, active-low.
module seg7_decode (
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    logic [6:0] seg_on;

    always_comb begin
        seg_on = 7'h00;
        case (nibble)
            4'h0: seg_on = 7'h3F;
            4'h1: seg_on = 7'h06;
            4'h2: seg_on = 7'h5B;
            4'h3: seg_on = 7'h4F;
            4'h4: seg_on = 7'h66;
            4'h5: seg_on = 7'h6D;
            4'h6: seg_on = 7'h7D;
            4'h7: seg_on = 7'h07;
            4'h8: seg_on = 7'h7F;
            4'h9: seg_on = 7'h6F;
            4'hA: seg_on = 7'h77;
            4'hB: seg_on = 7'h7C;
            4'hC: seg_on = 7'h39;
            4'hD: seg_on = 7'h5E;
            4'hE: seg_on = 7'h79;
            4'hF: seg_on = 7'h71;
            default: seg_on = 7'h00;
        endcase
        seg_n = ~seg_on;
    end

endmodule

// File: rtl/dig_display.sv
// Eight-digit multiplexed 7-segment display driver with a write-only register interface
// (value, digit-enable mask, decimal points). All outputs are registered.
module dig_display
    import dig_display_pkg::*;
#(
    parameter int unsigned  SCAN_CYCLES = 20000,
    parameter logic [31:0]  DATA_ADDR   = DIG_DATA_ADDR,
    parameter logic [31:0]  MASK_ADDR   = DIG_MASK_ADDR,
    parameter logic [31:0]  DP_ADDR     = DIG_DP_ADDR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [7:0]  dig_en,
    output logic        DN_A,
    output logic        DN_B,
    output logic        DN_C,
    output logic        DN_D,
    output logic        DN_E,
    output logic        DN_F,
    output logic        DN_G,
    output logic        DN_DP
);

    localparam int unsigned CW = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);

    logic [31:0]   data_q, data_d;
    logic [7:0]    mask_q, mask_d;
    logic [7:0]    dp_q, dp_d;
    logic [CW-1:0] scan_q, scan_d;
    logic [2:0]    idx_q, idx_d;
    disp_out_t     out_q, out_d;

    logic [3:0]    cur_nibble;
    logic [6:0]    cur_seg_n;

    seg7_decode u_seg7_decode (
        .nibble (cur_nibble),
        .seg_n  (cur_seg_n)
    );

    always_comb begin
        data_d = data_q;
        mask_d = mask_q;
        dp_d   = dp_q;
        if (we) begin
            if (addr == DATA_ADDR) data_d = wdata;
            if (addr == MASK_ADDR) mask_d = wdata[7:0];
            if (addr == DP_ADDR)   dp_d   = wdata[7:0];
        end
    end

    always_comb begin
        scan_d = scan_q + CW'(1);
        idx_d  = idx_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            idx_d  = idx_q + 3'd1;
        end
    end

    // Outputs follow the registered state, so a write or index step shows one edge later.
    always_comb begin
        cur_nibble = data_q[{idx_q, 2'b00} +: 4];
        out_d      = DISP_BLANK;
        if (mask_q[idx_q]) begin
            out_d.dig_en = ~(8'b1 << idx_q);
            out_d.seg_n  = cur_seg_n;
            out_d.dp_n   = ~dp_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
            mask_q <= 8'hFF;
            dp_q   <= '0;
            scan_q <= '0;
            idx_q  <= '0;
            out_q  <= DISP_BLANK;
        end else begin
            data_q <= data_d;
            mask_q <= mask_d;
            dp_q   <= dp_d;
            scan_q <= scan_d;
            idx_q  <= idx_d;
            out_q  <= out_d;
        end
    end

    assign dig_en = out_q.dig_en;
    assign DN_A   = out_q.seg_n[0];
    assign DN_B   = out_q.seg_n[1];
    assign DN_C   = out_q.seg_n[2];
    assign DN_D   = out_q.seg_n[3];
    assign DN_E   = out_q.seg_n[4];
    assign DN_F   = out_q.seg_n[5];
    assign DN_G   = out_q.seg_n[6];
    assign DN_DP  = out_q.dp_n;

endmodule

// File: tb/tb_dig_display.sv
// Bench for dig_display with SCAN_CYCLES=4: a cycle-count reference model predicts each
// registered output word, pushes it to a queue and compares it one edge later.
module tb_dig_display;

    localparam int unsigned SCAN = 4;
    localparam logic [31:0] A_DATA = 32'hFFFF_F000;
    localparam logic [31:0] A_MASK = 32'hFFFF_F004;
    localparam logic [31:0] A_DP   = 32'hFFFF_F008;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [31:0] wdata = '0;
    logic [7:0]  dig_en;
    logic        dn_a, dn_b, dn_c, dn_d, dn_e, dn_f, dn_g, dn_dp;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] exp_q[$];

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [31:0] m_data;
    logic [7:0]  m_mask;
    logic [7:0]  m_dp;
    int          m_tick;

    dig_display #(.SCAN_CYCLES(SCAN)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr   (addr),
        .we     (we),
        .wdata  (wdata),
        .dig_en (dig_en),
        .DN_A   (dn_a),
        .DN_B   (dn_b),
        .DN_C   (dn_c),
        .DN_D   (dn_d),
        .DN_E   (dn_e),
        .DN_F   (dn_f),
        .DN_G   (dn_g),
        .DN_DP  (dn_dp)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] predict();
        int   i;
        logic [15:0] r;
        if (!rst_n) return 16'hFFFF;
        i = (m_tick / SCAN) % 8;
        r = 16'hFFFF;
        if (m_mask[i]) begin
            r[15:8] = 8'hFF;
            r[8 + i] = 1'b0;
            r[7:1]  = ~hex_tab[m_data[4*i +: 4]];
            r[0]    = ~m_dp[i];
        end
        return r;
    endfunction

    function automatic logic [15:0] observed();
        return {dig_en, dn_g, dn_f, dn_e, dn_d, dn_c, dn_b, dn_a, dn_dp};
    endfunction

    // One clock: inputs are already driven; predict, clock, update the model, compare.
    task automatic step(input string name);
        logic [15:0] exp_v;
        logic [15:0] got;
        exp_q.push_back(predict());
        @(posedge clk);
        if (!rst_n) begin
            m_data = '0;
            m_mask = 8'hFF;
            m_dp   = '0;
            m_tick = 0;
        end else begin
            if (we && addr == A_DATA) m_data = wdata;
            if (we && addr == A_MASK) m_mask = wdata[7:0];
            if (we && addr == A_DP)   m_dp   = wdata[7:0];
            m_tick++;
        end
        #1;
        exp_v = exp_q.pop_front();
        got   = observed();
        vectors++;
        if (got !== exp_v) begin
            miscompares++;
            $display("FAIL %s t=%0t: got dig_en=%h seg=%b dp=%b, expected dig_en=%h seg=%b dp=%b",
                     name, $time, got[15:8], got[7:1], got[0], exp_v[15:8], exp_v[7:1], exp_v[0]);
        end
    endtask

    task automatic bus_write(input string name, input logic [31:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        step(name);
        we = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic idle(input string name, input int n);
        for (int k = 0; k < n; k++) step(name);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle("reset", 3);
        if (observed() !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, expected ffff", observed());
        end
        vectors++;
        rst_n = 1'b1;
        step("first_after_reset");
        vectors++;
        if (dig_en !== 8'hFE || {dn_g, dn_f, dn_e, dn_d, dn_c, dn_b, dn_a} !== 7'b1000000) begin
            miscompares++;
            $display("FAIL first_digit: got dig_en=%h seg=%b, expected fe 1000000",
                     dig_en, {dn_g, dn_f, dn_e, dn_d, dn_c, dn_b, dn_a});
        end
    endtask

    task automatic test_idle_scan();
        idle("idle_scan", 32);
    endtask

    task automatic test_data_write();
        bus_write("data_write", A_DATA, 32'h89AB_CDEF);
        idle("data_scan", 32);
    endtask

    task automatic test_mask();
        bus_write("mask_write", A_MASK, 32'h0000_000F);
        idle("mask_scan", 32);
        bus_write("mask_restore", A_MASK, 32'h0000_00FF);
    endtask

    task automatic test_dp();
        bus_write("dp_write", A_DP, 32'h0000_0001);
        idle("dp_scan", 32);
    endtask

    task automatic test_ignored();
        bus_write("bad_addr", 32'hFFFF_F00C, 32'hFFFF_FFFF);
        idle("bad_addr_scan", 8);
        we = 1'b0; addr = A_DATA; wdata = 32'h1234_5678;
        idle("we_low", 8);
        addr = '0; wdata = '0;
        idle("ignored_scan", 24);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        for (int k = 0; k < 120; k++) begin
            case ($urandom_range(0, 4))
                0: a = A_DATA;
                1: a = A_MASK;
                2: a = A_DP;
                3: a = 32'hFFFF_F00C;
                default: a = $urandom;
            endcase
            we    = ($urandom_range(0, 2) != 0);
            addr  = a;
            wdata = $urandom;
            step("back_to_back");
        end
        we = 1'b0; addr = '0; wdata = '0;
        idle("b2b_drain", 16);
    endtask

    task automatic test_reset_with_write();
        idle("pre_reset", 6);
        rst_n = 1'b0; we = 1'b1; addr = A_DATA; wdata = 32'hDEAD_BEEF;
        step("reset_with_write");
        we = 1'b0; addr = '0; wdata = '0;
        step("reset_hold");
        rst_n = 1'b1;
        idle("post_reset", 32);
    endtask

    initial begin
        m_data = '0; m_mask = 8'hFF; m_dp = '0; m_tick = 0;
        test_reset();
        test_idle_scan();
        test_data_write();
        test_mask();
        test_dp();
        test_ignored();
        test_back_to_back();
        test_reset_with_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
